// File: rtl/ddr_mem_responder.sv
// ddr_mem_responder: Avalon-MM style memory responder backing a 2^ADDR_W x 64-bit
// on-chip VRAM image for the GPU DDR master port. Handles one outstanding read or
// write burst at a time, applies per-byte write enables, returns read beats after
// READ_LATENCY cycles and raises a sticky flag on protocol violations.
//
// Ports:
//   clk               rising-edge clock
//   i_nrst            synchronous active-low reset
//   i_targetAddr      burst start word address (sampled on accepted command)
//   i_burstLength     beat count 1..7 (0 behaves as 1)
//   i_readEnableMem   read command request
//   i_writeEnableMem  write command / write beat request
//   i_dataMem         write data
//   i_byteEnableMem   per-byte write enable
//   i_stallInject     forces wait request while idle
//   o_busyMem         wait request; commands accepted only when low
//   o_dataValidMem    read beat valid
//   o_dataMem         read beat data (0 when not valid)
//   o_protocolError   sticky protocol violation flag
module ddr_mem_responder #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              i_nrst,
  input  logic [ADDR_W-1:0] i_targetAddr,
  input  logic [2:0]        i_burstLength,
  input  logic              i_readEnableMem,
  input  logic              i_writeEnableMem,
  input  logic [63:0]       i_dataMem,
  input  logic [7:0]        i_byteEnableMem,
  input  logic              i_stallInject,
  output logic              o_busyMem,
  output logic              o_dataValidMem,
  output logic [63:0]       o_dataMem,
  output logic              o_protocolError
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  // RD_WAIT lasts READ_LATENCY-1 cycles; the counter holds cycles left minus one.
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_WAIT,
    RD_BURST
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              perr, perr_n;
  logic              valid;
  logic [DATA_W-1:0] data;

  logic              load_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [LEN_W-1:0]  len_eff_c;

  assign len_eff_c = (i_burstLength == '0) ? LEN_W'(1) : i_burstLength;

  // Next-state, wait request and memory access control.
  // load_c: a read beat is fetched this edge and presented next cycle.
  // rem: in reads, beats still to fetch; in writes, beats still to accept.
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    rem_n     = rem;
    cnt_n     = cnt;
    perr_n    = perr;
    load_c    = 1'b0;
    rd_addr_c = addr;
    wr_en_c   = 1'b0;
    wr_addr_c = addr;
    o_busyMem = 1'b1;

    unique case (state)
      IDLE: begin
        o_busyMem = i_stallInject;
        rd_addr_c = i_targetAddr;
        wr_addr_c = i_targetAddr;
        if (!i_stallInject) begin
          if (i_writeEnableMem) begin
            // Write wins over a simultaneous read; the read is dropped.
            wr_en_c = 1'b1;
            addr_n  = i_targetAddr + ADDR_W'(1);
            rem_n   = len_eff_c - LEN_W'(1);
            if (len_eff_c != LEN_W'(1)) begin
              state_n = WR_BURST;
            end
            if (i_readEnableMem) begin
              perr_n = 1'b1;
            end
          end else if (i_readEnableMem) begin
            if (READ_LATENCY <= 1) begin
              load_c  = 1'b1;
              addr_n  = i_targetAddr + ADDR_W'(1);
              rem_n   = len_eff_c - LEN_W'(1);
              state_n = RD_BURST;
            end else begin
              addr_n  = i_targetAddr;
              rem_n   = len_eff_c;
              cnt_n   = WAIT_INIT;
              state_n = RD_WAIT;
            end
          end
        end
      end

      WR_BURST: begin
        o_busyMem = 1'b0;
        if (i_readEnableMem) begin
          perr_n = 1'b1;
        end
        if (i_writeEnableMem) begin
          wr_en_c = 1'b1;
          addr_n  = addr + ADDR_W'(1);
          rem_n   = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_n = IDLE;
          end
        end
      end

      RD_WAIT: begin
        if (cnt == '0) begin
          load_c  = 1'b1;
          addr_n  = addr + ADDR_W'(1);
          rem_n   = rem - LEN_W'(1);
          state_n = RD_BURST;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      RD_BURST: begin
        if (rem != '0) begin
          load_c = 1'b1;
          addr_n = addr + ADDR_W'(1);
          rem_n  = rem - LEN_W'(1);
        end else begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered read-return path.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
      cnt   <= '0;
      perr  <= 1'b0;
      valid <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      rem   <= rem_n;
      cnt   <= cnt_n;
      perr  <= perr_n;
      valid <= load_c;
      data  <= load_c ? mem[rd_addr_c] : '0;
    end
  end

  // Byte-masked memory write; contents survive reset, writes blocked while in reset.
  always_ff @(posedge clk) begin
    if (wr_en_c && i_nrst) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_byteEnableMem[b]) begin
          mem[wr_addr_c][8*b +: 8] <= i_dataMem[8*b +: 8];
        end
      end
    end
  end

  assign o_dataValidMem  = valid;
  assign o_dataMem       = data;
  assign o_protocolError = perr;

endmodule

// File: tb/tb_ddr_mem_responder.sv
// tb_ddr_mem_responder: self-checking bench for ddr_mem_responder. A reference
// memory model produces expected read data, pushed to a queue as reads are issued
// and popped by a monitor as beats appear. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_ddr_mem_responder;

  localparam int unsigned AW = 17;
  localparam int unsigned RL = 2;

  logic          clk = 1'b0;
  logic          i_nrst;
  logic [AW-1:0] i_targetAddr;
  logic [2:0]    i_burstLength;
  logic          i_readEnableMem;
  logic          i_writeEnableMem;
  logic [63:0]   i_dataMem;
  logic [7:0]    i_byteEnableMem;
  logic          i_stallInject;
  logic          o_busyMem;
  logic          o_dataValidMem;
  logic [63:0]   o_dataMem;
  logic          o_protocolError;

  int            errors = 0;
  int            checks = 0;
  logic [63:0]   exp_q[$];
  logic [63:0]   wdata[$];
  logic [63:0]   model[int];
  bit            mon_en = 1'b0;
  logic [63:0]   mon_exp;

  always #5 clk = ~clk;

  ddr_mem_responder #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk              (clk),
    .i_nrst           (i_nrst),
    .i_targetAddr     (i_targetAddr),
    .i_burstLength    (i_burstLength),
    .i_readEnableMem  (i_readEnableMem),
    .i_writeEnableMem (i_writeEnableMem),
    .i_dataMem        (i_dataMem),
    .i_byteEnableMem  (i_byteEnableMem),
    .i_stallInject    (i_stallInject),
    .o_busyMem        (o_busyMem),
    .o_dataValidMem   (o_dataValidMem),
    .o_dataMem        (o_dataMem),
    .o_protocolError  (o_protocolError)
  );

  // Scoreboard monitor: every valid beat must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (o_dataValidMem === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", o_dataMem);
        end else begin
          mon_exp = exp_q.pop_front();
          if (o_dataMem !== mon_exp) begin
            errors++;
            $display("FAIL read_data: got %h, expected %h", o_dataMem, mon_exp);
          end
        end
      end else if (o_dataMem !== 64'd0) begin
        errors++;
        $display("FAIL idle_data: got %h, expected 0", o_dataMem);
      end
    end
  end

  function automatic void model_wr(input logic [AW-1:0] a, input logic [63:0] d,
                                   input logic [7:0] be);
    logic [63:0] cur;
    cur = model.exists(int'(a)) ? model[int'(a)] : 64'd0;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
    end
    model[int'(a)] = cur;
  endfunction

  function automatic logic [63:0] model_rd(input logic [AW-1:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : 64'd0;
  endfunction

  task automatic idle_inputs();
    i_readEnableMem  = 1'b0;
    i_writeEnableMem = 1'b0;
    i_stallInject    = 1'b0;
    i_targetAddr     = '0;
    i_burstLength    = 3'd0;
    i_dataMem        = 64'd0;
    i_byteEnableMem  = 8'h00;
  endtask

  // Writes the words in wdata as one burst; gap_at inserts an idle cycle before that beat.
  task automatic write_beats(input logic [AW-1:0] a, input logic [7:0] be, input int gap_at);
    int n;
    n = wdata.size();
    @(negedge clk);
    checks++;
    if (o_busyMem !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready: busy=%b, expected 0", o_busyMem);
    end
    i_writeEnableMem = 1'b1;
    i_targetAddr     = a;
    i_burstLength    = 3'(n);
    i_dataMem        = wdata[0];
    i_byteEnableMem  = be;
    model_wr(a, wdata[0], be);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (i == gap_at) begin
        i_writeEnableMem = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (o_busyMem !== 1'b0) begin
        errors++;
        $display("FAIL wr_burst_busy: beat %0d busy=%b, expected 0", i, o_busyMem);
      end
      i_writeEnableMem = 1'b1;
      i_dataMem        = wdata[i];
      model_wr(a + AW'(i), wdata[i], be);
    end
    @(negedge clk);
    i_writeEnableMem = 1'b0;
  endtask

  // Issues a read (after one falling edge when sync=1) and checks beat count and timing.
  task automatic read_burst(input logic [AW-1:0] a, input logic [2:0] n, input bit sync);
    int beats;
    int seen;
    int first_k;
    int busy_cycles;
    bit done;
    beats = (n == 3'd0) ? 1 : int'(n);
    seen = 0;
    first_k = -1;
    busy_cycles = 0;
    done = 1'b0;
    if (sync) @(negedge clk);
    checks++;
    if (o_busyMem !== 1'b0) begin
      errors++;
      $display("FAIL rd_ready: busy=%b, expected 0", o_busyMem);
    end
    for (int i = 0; i < beats; i++) exp_q.push_back(model_rd(a + AW'(i)));
    i_writeEnableMem = 1'b0;
    i_readEnableMem  = 1'b1;
    i_targetAddr     = a;
    i_burstLength    = n;
    @(negedge clk);
    i_readEnableMem = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_busyMem === 1'b0) begin
        done = 1'b1;
        busy_cycles = k;
        break;
      end
      if (o_dataValidMem === 1'b1) begin
        if (first_k < 0) first_k = k;
        seen++;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rd_timeout: busy still 1 after 40 cycles, expected release");
    end
    checks++;
    if (seen != beats) begin
      errors++;
      $display("FAIL rd_beats: got %0d beats, expected %0d", seen, beats);
    end
    checks++;
    if (busy_cycles != int'(RL) + beats - 1) begin
      errors++;
      $display("FAIL rd_busy_len: got %0d busy cycles, expected %0d", busy_cycles,
               int'(RL) + beats - 1);
    end
    checks++;
    if (first_k != int'(RL) - 1) begin
      errors++;
      $display("FAIL rd_latency: first beat at T+%0d, expected T+%0d", first_k + 1, RL);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_leftover: %0d beats missing, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    i_nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_protocolError !== 1'b0 || o_busyMem !== 1'b0 || o_dataValidMem !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: perr=%b busy=%b valid=%b, expected 0 0 0",
               o_protocolError, o_busyMem, o_dataValidMem);
    end
    i_nrst = 1'b1;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (o_dataValidMem !== 1'b0) begin
        errors++;
        $display("FAIL %s: valid=%b at cycle %0d, expected 0", name, o_dataValidMem, i);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (o_busyMem !== 1'b0 || o_dataValidMem !== 1'b0 || o_dataMem !== 64'd0 ||
        o_protocolError !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b data=%h perr=%b, expected 0 0 0 0",
               o_busyMem, o_dataValidMem, o_dataMem, o_protocolError);
    end
    i_nrst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    wdata = '{64'h0123456789ABCDEF};
    write_beats(17'h00010, 8'hFF, -1);
    read_burst(17'h00010, 3'd1, 1'b1);
  endtask

  task automatic test_masked_burst();
    wdata = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    write_beats(17'h00100, 8'hFF, -1);
    wdata = '{64'd0, 64'd0, 64'd0, 64'd0};
    write_beats(17'h00100, 8'h0F, 2);
    checks++;
    if (model_rd(17'h00102) !== 64'hFFFFFFFF00000000) begin
      errors++;
      $display("FAIL masked_model: got %h, expected FFFFFFFF00000000", model_rd(17'h00102));
    end
    read_burst(17'h00100, 3'd4, 1'b1);
    // All-zero byte enable leaves the word untouched.
    wdata = '{64'h5555_5555_5555_5555};
    write_beats(17'h00101, 8'h00, -1);
    read_burst(17'h00101, 3'd1, 1'b1);
  endtask

  task automatic test_wrap();
    wdata = '{64'd1, 64'd2, 64'd3};
    write_beats(17'h1FFFF, 8'hFF, -1);
    read_burst(17'h1FFFF, 3'd1, 1'b1);
    read_burst(17'h00000, 3'd1, 1'b1);
    read_burst(17'h00001, 3'd1, 1'b1);
    read_burst(17'h1FFFF, 3'd3, 1'b1);
  endtask

  task automatic test_back_to_back();
    // Read accepted the cycle after the write must see the new data.
    @(negedge clk);
    i_writeEnableMem = 1'b1;
    i_targetAddr     = 17'h00500;
    i_burstLength    = 3'd1;
    i_dataMem        = 64'hA5A5_0000_1234_5678;
    i_byteEnableMem  = 8'hFF;
    model_wr(17'h00500, 64'hA5A5_0000_1234_5678, 8'hFF);
    read_burst(17'h00500, 3'd1, 1'b1);
    // Next read issued in the very cycle wait request drops.
    read_burst(17'h00500, 3'd1, 1'b0);
    wdata.delete();
    for (int i = 0; i < 7; i++) wdata.push_back(64'h4000_0000_0000_0000 + 64'(i * 17));
    write_beats(17'h00400, 8'hFF, -1);
    read_burst(17'h00400, 3'd7, 1'b1);
    read_burst(17'h00403, 3'd2, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_q.push_back(model_rd(17'h00010));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (o_busyMem !== 1'b1) begin
          errors++;
          $display("FAIL stall_busy: busy=%b at stall cycle %0d, expected 1", o_busyMem, i);
        end
      end
      checks++;
      if (o_dataValidMem !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid: valid=%b at stall cycle %0d, expected 0", o_dataValidMem, i);
      end
      i_stallInject   = 1'b1;
      i_readEnableMem = 1'b1;
      i_targetAddr    = 17'h00010;
      i_burstLength   = 3'd1;
    end
    @(negedge clk);
    checks++;
    if (o_dataValidMem !== 1'b0) begin
      errors++;
      $display("FAIL stall_valid_last: valid=%b, expected 0", o_dataValidMem);
    end
    i_stallInject = 1'b0;
    @(negedge clk);
    i_readEnableMem = 1'b0;
    checks++;
    if (o_busyMem !== 1'b1 || o_dataValidMem !== 1'b0) begin
      errors++;
      $display("FAIL bp_t1: busy=%b valid=%b, expected 1 0", o_busyMem, o_dataValidMem);
    end
    @(negedge clk);
    checks++;
    if (o_busyMem !== 1'b1 || o_dataValidMem !== 1'b1) begin
      errors++;
      $display("FAIL bp_t2: busy=%b valid=%b, expected 1 1", o_busyMem, o_dataValidMem);
    end
    @(negedge clk);
    checks++;
    if (o_busyMem !== 1'b0 || o_dataValidMem !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_t3: busy=%b valid=%b pending=%0d, expected 0 0 0",
               o_busyMem, o_dataValidMem, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_protocol();
    @(negedge clk);
    checks++;
    if (o_protocolError !== 1'b0) begin
      errors++;
      $display("FAIL perr_pre: perr=%b, expected 0", o_protocolError);
    end
    i_writeEnableMem = 1'b1;
    i_readEnableMem  = 1'b1;
    i_targetAddr     = 17'h00200;
    i_burstLength    = 3'd1;
    i_dataMem        = 64'hDEAD_BEEF_CAFE_F00D;
    i_byteEnableMem  = 8'hFF;
    model_wr(17'h00200, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (o_protocolError !== 1'b1 || o_busyMem !== 1'b0) begin
      errors++;
      $display("FAIL perr_both: perr=%b busy=%b, expected 1 0", o_protocolError, o_busyMem);
    end
    expect_quiet("perr_no_read", 4);
    pulse_reset();
    read_burst(17'h00200, 3'd1, 1'b1);
    // Read request in the middle of a write burst.
    @(negedge clk);
    i_writeEnableMem = 1'b1;
    i_targetAddr     = 17'h00300;
    i_burstLength    = 3'd2;
    i_dataMem        = 64'h1111_2222_3333_4444;
    i_byteEnableMem  = 8'hFF;
    model_wr(17'h00300, 64'h1111_2222_3333_4444, 8'hFF);
    @(negedge clk);
    i_readEnableMem = 1'b1;
    i_dataMem       = 64'h5555_6666_7777_8888;
    model_wr(17'h00301, 64'h5555_6666_7777_8888, 8'hFF);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (o_protocolError !== 1'b1 || o_busyMem !== 1'b0) begin
      errors++;
      $display("FAIL perr_wrburst: perr=%b busy=%b, expected 1 0", o_protocolError, o_busyMem);
    end
    expect_quiet("perr_wr_no_read", 4);
    pulse_reset();
    read_burst(17'h00300, 3'd2, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    exp_q.push_back(model_rd(17'h00400));
    exp_q.push_back(model_rd(17'h00401));
    i_readEnableMem = 1'b1;
    i_targetAddr    = 17'h00400;
    i_burstLength   = 3'd7;
    @(negedge clk);
    i_readEnableMem = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (o_dataValidMem !== 1'b1) begin
        errors++;
        $display("FAIL mid_beat: beat %0d valid=%b, expected 1", i, o_dataValidMem);
      end
    end
    i_nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_dataValidMem !== 1'b0 || o_busyMem !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b pending=%0d, expected 0 0 0",
               o_dataValidMem, o_busyMem, exp_q.size());
    end
    exp_q.delete();
    i_nrst = 1'b1;
    expect_quiet("mid_abort", 6);
    read_burst(17'h00402, 3'd3, 1'b1);
  endtask

  task automatic test_len_zero();
    read_burst(17'h00010, 3'd0, 1'b1);
  endtask

  initial begin
    i_nrst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_masked_burst();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_protocol();
    test_reset_mid_read();
    test_len_zero();
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
